card_shoe: RTL and testbench

Multi-deck card shoe that deals without replacement. It is the successor to the single-deck RNG dealer.
- Keeps a per-rank count of the cards left across NUM_DECKS decks.
- Picks each card from a free-running LFSR, then probes forward to the next rank that still has cards.
- Supports shuffle (refill), an empty error and a penetration-based reshuffle flag.
- Sits between the game-control FSM (player/dealer hit requests) and the hand-score accumulators.

---
 rtl/card_pkg.sv | 21 ++
 rtl/card_lfsr.sv | 34 +++
 rtl/card_shoe.sv | 132 +++++++++++++
 tb/tb_card_shoe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared card/rank types, shoe constants and the rank-to-blackjack-value helper.
package card_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] rank_t;

  localparam int unsigned NUM_RANKS               = 13;
  localparam int unsigned CARDS_PER_RANK_PER_DECK = 4;
  localparam int unsigned FACE_VALUE              = 10;
  localparam int unsigned LFSR_W                  = 16;
  localparam logic [15:0] LFSR_TAPS               = 16'hB400;

  // Ace=1, 2..9 face value, 10/J/Q/K all count as ten.
  function automatic card_t rank_to_value(input rank_t rank);
    if (rank >= rank_t'(9)) begin
      return card_t'(FACE_VALUE);
    end
    return card_t'(rank + rank_t'(1));
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module card_lfsr
  import card_pkg::*;
#(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(LFSR_TAPS),
  parameter int unsigned       OUT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] rnd
);

  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_nx;

  always_comb begin
    state_nx = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED_NZ;
    end else begin
      state_q <= state_nx;
    end
  end

  assign rnd = state_q[OUT_W-1:0];

endmodule

// File: rtl/card_shoe.sv
// Multi-deck shoe dealing without replacement: LFSR picks a start rank, then the
// shoe probes forward to the next rank that still holds cards.
module card_shoe
  import card_pkg::*;
#(
  parameter int unsigned NUM_DECKS    = 1,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned RESHUFFLE_AT = 13
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_card,
  input  logic                                shuffle,
  output card_t                               dealt_card,
  output rank_t                               dealt_rank,
  output logic                                deal_valid,
  output logic                                deal_error,
  output logic                                busy,
  output logic [$clog2(52*NUM_DECKS+1)-1:0]   cards_remaining,
  output logic                                needs_shuffle
);

  localparam int unsigned TOTAL    = NUM_RANKS * CARDS_PER_RANK_PER_DECK * NUM_DECKS;
  localparam int unsigned REM_W    = $clog2(52 * NUM_DECKS + 1);
  localparam int unsigned PER_RANK = CARDS_PER_RANK_PER_DECK * NUM_DECKS;
  localparam int unsigned CNT_W    = $clog2(PER_RANK + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] PROBE = 1'b1;

  logic [0:0]       state, state_nx;
  rank_t            probe_idx, probe_nx;
  logic [CNT_W-1:0] rank_count [NUM_RANKS];
  logic [CNT_W-1:0] count_nx   [NUM_RANKS];
  logic [REM_W-1:0] remaining_nx;
  card_t            card_nx;
  rank_t            rank_nx;
  logic             valid_nx;
  logic             error_nx;
  logic             busy_nx;
  logic [3:0]       lfsr_low;
  rank_t            idx0;

  card_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (SEED),
    .OUT_W (4)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (lfsr_low)
  );

  // Fold 13..15 back onto 0..2; the slight bias is acceptable.
  assign idx0 = (lfsr_low >= 4'(NUM_RANKS)) ? rank_t'(lfsr_low - 4'(NUM_RANKS)) : rank_t'(lfsr_low);

  always_comb begin
    state_nx     = state;
    probe_nx     = probe_idx;
    count_nx     = rank_count;
    remaining_nx = cards_remaining;
    card_nx      = dealt_card;
    rank_nx      = dealt_rank;
    valid_nx     = 1'b0;
    error_nx     = 1'b0;
    unique case (state)
      IDLE: begin
        if (shuffle) begin
          for (int unsigned r = 0; r < NUM_RANKS; r++) count_nx[r] = CNT_W'(PER_RANK);
          remaining_nx = REM_W'(TOTAL);
          card_nx      = '0;
          rank_nx      = '0;
        end else if (req_card) begin
          if (cards_remaining == '0) begin
            error_nx = 1'b1;
          end else begin
            probe_nx = idx0;
            state_nx = PROBE;
          end
        end
      end
      PROBE: begin
        if (shuffle) begin
          for (int unsigned r = 0; r < NUM_RANKS; r++) count_nx[r] = CNT_W'(PER_RANK);
          remaining_nx = REM_W'(TOTAL);
          card_nx      = '0;
          rank_nx      = '0;
          state_nx     = IDLE;
        end else if (rank_count[probe_idx] != '0) begin
          count_nx[probe_idx] = rank_count[probe_idx] - CNT_W'(1);
          remaining_nx        = cards_remaining - REM_W'(1);
          rank_nx             = probe_idx;
          card_nx             = rank_to_value(probe_idx);
          valid_nx            = 1'b1;
          state_nx            = IDLE;
        end else begin
          // Termination is guaranteed: PROBE is entered only with cards left.
          probe_nx = (probe_idx == rank_t'(NUM_RANKS - 1)) ? '0 : probe_idx + rank_t'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == PROBE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      probe_idx       <= '0;
      for (int unsigned r = 0; r < NUM_RANKS; r++) rank_count[r] <= CNT_W'(PER_RANK);
      cards_remaining <= REM_W'(TOTAL);
      dealt_card      <= '0;
      dealt_rank      <= '0;
      deal_valid      <= 1'b0;
      deal_error      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nx;
      probe_idx       <= probe_nx;
      rank_count      <= count_nx;
      cards_remaining <= remaining_nx;
      dealt_card      <= card_nx;
      dealt_rank      <= rank_nx;
      deal_valid      <= valid_nx;
      deal_error      <= error_nx;
      busy            <= busy_nx;
    end
  end

  assign needs_shuffle = (32'(cards_remaining) < RESHUFFLE_AT);

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: a 1-deck and a 6-deck instance, each shadowed by
// an independent LFSR/rank-count model that predicts every dealt card.
module tb_card_shoe;
  import card_pkg::*;

  localparam int unsigned REM0_W = $clog2(53);
  localparam int unsigned REM1_W = $clog2(313);
  localparam logic [15:0] SEED   = 16'hACE1;

  typedef struct packed {
    logic       err;
    logic [3:0] rank;
    logic [3:0] value;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic [1:0]      rst, req, shuf;
  logic [1:0]      dv, de, bsy, ns;
  logic [1:0][3:0] dc, dr;
  logic [REM0_W-1:0] rem0;
  logic [REM1_W-1:0] rem1;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   m_count [2][13];
  int   m_rem   [2];
  logic [15:0] m_lfsr [2];
  exp_t sb [2][$];
  int   rank_hist [2][13];
  int   val_hist  [2][11];
  int   n_deals   [2];
  int   n_err     [2];
  int   last_deal [2];

  card_shoe #(.NUM_DECKS(1), .SEED(SEED), .RESHUFFLE_AT(13)) u_shoe0 (
    .clk(clk), .reset(rst[0]), .req_card(req[0]), .shuffle(shuf[0]),
    .dealt_card(dc[0]), .dealt_rank(dr[0]), .deal_valid(dv[0]), .deal_error(de[0]),
    .busy(bsy[0]), .cards_remaining(rem0), .needs_shuffle(ns[0])
  );

  card_shoe #(.NUM_DECKS(6), .SEED(SEED), .RESHUFFLE_AT(13)) u_shoe1 (
    .clk(clk), .reset(rst[1]), .req_card(req[1]), .shuffle(shuf[1]),
    .dealt_card(dc[1]), .dealt_rank(dr[1]), .deal_valid(dv[1]), .deal_error(de[1]),
    .busy(bsy[1]), .cards_remaining(rem1), .needs_shuffle(ns[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int decks_of(input int d);
    return (d == 0) ? 1 : 6;
  endfunction

  function automatic int value_of(input int rank);
    return (rank >= 9) ? 10 : rank + 1;
  endfunction

  // Model: check outputs of the last edge, then predict what the next edge does.
  always @(negedge clk) begin
    int   r_obs, lat, idx, sum0, sum1;
    exp_t e;
    cyc++;
    sum0 = 0;
    sum1 = 0;
    for (int r = 0; r < 13; r++) begin
      sum0 += int'(u_shoe0.rank_count[r]);
      sum1 += int'(u_shoe1.rank_count[r]);
    end
    check("d0_count_sum", sum0, int'(rem0));
    check("d1_count_sum", sum1, int'(rem1));
    for (int d = 0; d < 2; d++) begin
      r_obs = (d == 0) ? int'(rem0) : int'(rem1);
      if (dv[d] && de[d]) check($sformatf("d%0d_pulse_exclusive", d), 1, 0);
      if (dv[d]) begin
        if (sb[d].size() == 0) begin
          check($sformatf("d%0d_unexpected_deal", d), 1, 0);
        end else begin
          e = sb[d].pop_front();
          check($sformatf("d%0d_deal_not_error", d), int'(e.err), 0);
          check($sformatf("d%0d_rank", d), int'(dr[d]), int'(e.rank));
          check($sformatf("d%0d_value", d), int'(dc[d]), int'(e.value));
          lat = cyc - e.cyc;
          check($sformatf("d%0d_latency_2_14", d), int'(lat >= 2 && lat <= 14), 1);
          if (!e.err) begin
            m_count[d][e.rank]--;
            m_rem[d]--;
          end
        end
        check($sformatf("d%0d_remaining", d), r_obs, m_rem[d]);
        check($sformatf("d%0d_needs_shuffle", d), int'(ns[d]), int'(m_rem[d] < 13));
        if (dr[d] < 4'd13) rank_hist[d][dr[d]]++;
        if (dc[d] <= 4'd10) val_hist[d][dc[d]]++;
        if (d == 1 && n_deals[1] > 0 && req[1])
          check("d1_spacing_2_14", int'((cyc - last_deal[1]) >= 2 && (cyc - last_deal[1]) <= 14), 1);
        last_deal[d] = cyc;
        n_deals[d]++;
      end
      if (de[d]) begin
        n_err[d]++;
        if (sb[d].size() == 0) begin
          check($sformatf("d%0d_unexpected_error", d), 1, 0);
        end else begin
          e = sb[d].pop_front();
          check($sformatf("d%0d_error_expected", d), int'(e.err), 1);
          check($sformatf("d%0d_error_latency", d), cyc - e.cyc, 1);
        end
      end
      if (sb[d].size() > 0 && (cyc - sb[d][0].cyc) > 14) begin
        check($sformatf("d%0d_response_timeout", d), 0, 1);
        void'(sb[d].pop_front());
      end
      if (rst[d] || shuf[d]) begin
        for (int r = 0; r < 13; r++) m_count[d][r] = 4 * decks_of(d);
        m_rem[d] = 52 * decks_of(d);
        sb[d].delete();
      end else if (req[d] && !bsy[d]) begin
        e.cyc  = cyc;
        e.err  = (m_rem[d] == 0);
        e.rank = '0;
        e.value = '0;
        if (!e.err) begin
          idx = int'(m_lfsr[d][3:0]);
          if (idx >= 13) idx -= 13;
          for (int k = 0; k < 13 && m_count[d][idx] == 0; k++) idx = (idx == 12) ? 0 : idx + 1;
          e.rank  = 4'(idx);
          e.value = 4'(value_of(idx));
        end
        sb[d].push_back(e);
      end
      m_lfsr[d] = rst[d] ? SEED : lfsr_step(m_lfsr[d]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deal_one(input int d);
    req[d] = 1'b1;
    tick();
    req[d] = 1'b0;
    for (int i = 0; i < 20 && sb[d].size() != 0; i++) tick();
  endtask

  initial begin
    int errs_before, deals_before, busy_hits, budget;
    rst = 2'b11; req = '0; shuf = '0;
    for (int d = 0; d < 2; d++) begin
      n_deals[d] = 0; n_err[d] = 0; last_deal[d] = 0; m_rem[d] = 0; m_lfsr[d] = SEED;
      for (int r = 0; r < 13; r++) begin m_count[d][r] = 0; rank_hist[d][r] = 0; end
      for (int v = 0; v < 11; v++) val_hist[d][v] = 0;
    end
    repeat (3) tick();
    rst = 2'b00;
    tick();

    // Reset state
    check("reset_rem0", int'(rem0), 52);
    check("reset_rem1", int'(rem1), 312);
    check("reset_needs_shuffle", int'(ns[0]), 0);
    check("reset_deal_valid", int'(dv[0]), 0);
    check("reset_dealt_card", int'(dc[0]), 0);
    check("reset_busy", int'(bsy[0]), 0);

    // Drain a single deck, watching needs_shuffle cross at 12 remaining
    for (int i = 0; i < 52; i++) begin
      deal_one(0);
      if (i == 38) begin
        check("before_40th_rem", int'(rem0), 13);
        check("before_40th_needs_shuffle", int'(ns[0]), 0);
      end
      if (i == 39) begin
        check("after_40th_rem", int'(rem0), 12);
        check("after_40th_needs_shuffle", int'(ns[0]), 1);
      end
    end
    check("deck_deal_count", n_deals[0], 52);
    check("deck_empty", int'(rem0), 0);
    for (int r = 0; r < 13; r++) check($sformatf("deck_rank%0d_count", r), rank_hist[0][r], 4);
    for (int v = 1; v <= 10; v++) check($sformatf("deck_value%0d_count", v), val_hist[0][v], (v == 10) ? 16 : 4);

    // Request from an empty shoe
    errs_before = n_err[0];
    deals_before = n_deals[0];
    busy_hits = 0;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bsy[0]) busy_hits++;
      tick();
    end
    check("empty_error_pulses", n_err[0] - errs_before, 1);
    check("empty_no_deal", n_deals[0] - deals_before, 0);
    check("empty_busy_stays_low", busy_hits, 0);

    // Shuffle in IDLE refills and clears the dealt card
    shuf[0] = 1'b1;
    tick();
    shuf[0] = 1'b0;
    check("shuffle_rem", int'(rem0), 52);
    check("shuffle_dealt_card", int'(dc[0]), 0);

    // Shuffle in the first PROBE cycle aborts the draw
    deals_before = n_deals[0];
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    check("abort_in_probe", int'(bsy[0]), 1);
    shuf[0] = 1'b1;
    tick();
    shuf[0] = 1'b0;
    check("abort_no_valid", int'(dv[0]), 0);
    check("abort_rem", int'(rem0), 52);
    repeat (3) tick();
    check("abort_no_deal", n_deals[0] - deals_before, 0);

    // Reset in the middle of a probe
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("midprobe_reset_valid", int'(dv[0]), 0);
    check("midprobe_reset_rem", int'(rem0), 52);
    check("midprobe_reset_busy", int'(bsy[0]), 0);
    repeat (3) tick();
    check("midprobe_reset_no_deal", n_deals[0] - deals_before, 0);

    // A few more fully predicted deals after reset
    for (int i = 0; i < 6; i++) deal_one(0);
    check("post_reset_rem", int'(rem0), 46);

    // Six decks, req_card held high through the whole shoe
    req[1] = 1'b1;
    budget = 312 * 15;
    while (n_deals[1] < 312 && budget > 0) begin
      tick();
      budget--;
    end
    req[1] = 1'b0;
    check("six_deck_budget_left", int'(budget > 0), 1);
    repeat (4) tick();
    check("six_deck_deals", n_deals[1], 312);
    check("six_deck_empty", int'(rem1), 0);
    for (int r = 0; r < 13; r++) check($sformatf("six_deck_rank%0d", r), rank_hist[1][r], 24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
